// File: rtl/arp_lookup_ctrl.sv
// rtl/arp_lookup_ctrl.sv - ARP table with linear-search lookup FSM and software access port
// Optional hit/miss statistics are enabled by defining ARP_LOOKUP_CTRL_STATS_EN.
module arp_lookup_ctrl #(
   parameter int ARP_DEPTH = 16,
   parameter int IDX_W     = 4
) (
   input  logic             AXI_ACLK,
   input  logic             AXI_RESETN,
   input  logic             lkp_req,
   input  logic [31:0]      lkp_ip,
   input  logic [7:0]       lkp_oq,
   output logic             lkp_ack,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             arp_hit,
   output logic [47:0]      dest_mac,
   output logic [31:0]      oq_reg,
   input  logic             sw_req,
   input  logic             sw_wr,
   input  logic [IDX_W-1:0] sw_idx,
   input  logic [31:0]      sw_ip,
   input  logic [47:0]      sw_mac,
   output logic             sw_ack,
   output logic [31:0]      sw_rd_ip,
   output logic [47:0]      sw_rd_mac
`ifdef ARP_LOOKUP_CTRL_STATS_EN
   ,
   output logic [31:0]      hit_count,
   output logic [31:0]      miss_count
`endif
);

   typedef enum logic [1:0] {ST_IDLE, ST_SEARCH, ST_RESP, ST_SW} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [31:0]      ip_q;
   logic [7:0]       oq_q;
   logic             hit_q;
   logic [47:0]      mac_q;
   logic             lkp_ack_q;
   logic             sw_ack_q;
   logic [31:0]      rd_ip_q;
   logic [47:0]      rd_mac_q;

   logic [31:0]      tbl_ip_q  [ARP_DEPTH];
   logic [47:0]      tbl_mac_q [ARP_DEPTH];

   logic             accept;
   logic             sw_go;
   logic             match;
   logic             last;

   // A zero lookup address never matches, which also keeps empty (ip==0) entries invisible.
   assign match = (ip_q != 32'd0) && (tbl_ip_q[idx_q] == ip_q);
   assign last  = (idx_q == IDX_W'(ARP_DEPTH - 1));

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      sw_go   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sw_req) begin
               state_d = ST_SW;
               sw_go   = 1'b1;
            end else if (lkp_req) begin
               state_d = ST_SEARCH;
               accept  = 1'b1;
            end
         end
         ST_SEARCH: if (match || last) state_d = ST_RESP;
         ST_RESP:   if (rsp_ready) state_d = ST_IDLE;
         ST_SW:     state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         state_q   <= ST_IDLE;
         idx_q     <= '0;
         ip_q      <= '0;
         oq_q      <= '0;
         hit_q     <= 1'b0;
         mac_q     <= '0;
         lkp_ack_q <= 1'b0;
         sw_ack_q  <= 1'b0;
         rd_ip_q   <= '0;
         rd_mac_q  <= '0;
      end else begin
         state_q   <= state_d;
         lkp_ack_q <= accept;
         sw_ack_q  <= sw_go;
         if (accept) begin
            ip_q  <= lkp_ip;
            oq_q  <= lkp_oq;
            idx_q <= '0;
         end
         if (state_q == ST_SEARCH) begin
            if (match) begin
               hit_q <= 1'b1;
               mac_q <= tbl_mac_q[idx_q];
            end else if (last) begin
               hit_q <= 1'b0;
               mac_q <= '0;
            end else begin
               idx_q <= idx_q + IDX_W'(1);
            end
         end
         // Read data is captured on entry to SW so it is valid while sw_ack is high.
         if (sw_go && !sw_wr) begin
            rd_ip_q  <= tbl_ip_q[sw_idx];
            rd_mac_q <= tbl_mac_q[sw_idx];
         end
      end
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         for (int i = 0; i < ARP_DEPTH; i++) begin
            tbl_ip_q[i]  <= '0;
            tbl_mac_q[i] <= '0;
         end
      end else if (state_q == ST_SW && sw_wr) begin
         tbl_ip_q[sw_idx]  <= sw_ip;
         tbl_mac_q[sw_idx] <= sw_mac;
      end
   end

`ifdef ARP_LOOKUP_CTRL_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == ST_RESP && rsp_ready) begin
         if (hit_q && hit_cnt_q != 32'hFFFF_FFFF)
            hit_cnt_q <= hit_cnt_q + 32'd1;
         if (!hit_q && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_q <= miss_cnt_q + 32'd1;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

   assign lkp_ack   = lkp_ack_q;
   assign rsp_valid = (state_q == ST_RESP);
   assign arp_hit   = hit_q;
   assign dest_mac  = mac_q;
   assign oq_reg    = {24'b0, oq_q};
   assign sw_ack    = sw_ack_q;
   assign sw_rd_ip  = rd_ip_q;
   assign sw_rd_mac = rd_mac_q;

endmodule
